// File: rtl/aes_pkg.sv
// Shared constants for the AES-128 key schedule: round count, FSM encoding
// and the round-constant table.
package aes_pkg;

    localparam int         AES_NR     = 10;
    localparam logic [3:0] LAST_ROUND = 4'd10;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_e;

    // Packed [10:1] so RCON[r] reads directly with the round number.
    localparam logic [10:1][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        if (r >= 4'd1 && r <= LAST_ROUND) v = RCON[r];
        return v;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] s;

    always_comb begin
        s = 8'h00;
        case (in_byte)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
            8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
            8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
            8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
            8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
            8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
            8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
            8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
            8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
            8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
            8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
            8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
            8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
            8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
            8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
            8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
            8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
            8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
            8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
            8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
            8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
            8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
            8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
            8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
            8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
            8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
            8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
            8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
            8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
            8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
            8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
            8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
            8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
    end

    assign out_byte = s;

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: streams round keys 0..10, one per clock,
// and keeps all of them in a buffer the decrypt path reads by index.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [127:0]     Key_In,
    output logic [127:0]     Round_Key,
    output logic [IDX_W-1:0] Round_Idx,
    output logic             Key_Valid,
    output logic             Busy,
    output logic             Done,
    output logic             Keys_Ready,
    input  logic [IDX_W-1:0] Rd_Addr,
    output logic [127:0]     Rd_Key
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [127:0]     key_q, key_d;
    logic             ready_q, ready_d;
    logic [127:0]     buf_q [0:NR];

    logic [31:0]      w0, w1, w2, w3, rot_w, sub_w, t_w;
    logic [31:0]      n0, n1, n2, n3;
    logic [127:0]     next_key;

    assign rot_w = {key_q[23:0], key_q[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .in_byte  (rot_w[8*g +: 8]),
            .out_byte (sub_w[8*g +: 8])
        );
    end

    always_comb begin
        w0 = key_q[127:96];
        w1 = key_q[95:64];
        w2 = key_q[63:32];
        w3 = key_q[31:0];
        t_w = sub_w ^ {rcon_of(4'(idx_q + 1'b1)), 24'h0};
        n0 = w0 ^ t_w;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        key_d   = key_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = EXPAND;
                    idx_d   = '0;
                    key_d   = Key_In;
                    ready_d = 1'b0;
                end
            end
            EXPAND: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                    key_d = next_key;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            key_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            ready_q <= ready_d;
        end
    end

    // Every presented round key lands in its slot at the end of its cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i <= NR; i++) buf_q[i] <= '0;
        end else if (state_q == EXPAND) begin
            buf_q[idx_q] <= key_q;
        end
    end

    always_comb begin
        Rd_Key = '0;
        if (Rd_Addr <= LAST_IDX) Rd_Key = buf_q[Rd_Addr];
    end

    assign Round_Key  = key_q;
    assign Round_Idx  = idx_q;
    assign Key_Valid  = (state_q == EXPAND);
    assign Busy       = (state_q == EXPAND);
    assign Done       = (state_q == EXPAND) && (idx_q == LAST_IDX);
    assign Keys_Ready = ready_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander; reference schedule uses an
// algebraically derived S-box (GF(2^8) inverse + affine map).
module tb_aes_key_expander;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         Start = 1'b0;
    logic [127:0] Key_In = '0;
    logic [3:0]   Rd_Addr = '0;
    logic [127:0] Round_Key;
    logic [3:0]   Round_Idx;
    logic         Key_Valid, Busy, Done, Keys_Ready;
    logic [127:0] Rd_Key;

    aes_key_expander dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Key_In(Key_In),
        .Round_Key(Round_Key), .Round_Idx(Round_Idx), .Key_Valid(Key_Valid),
        .Busy(Busy), .Done(Done), .Keys_Ready(Keys_Ready),
        .Rd_Addr(Rd_Addr), .Rd_Key(Rd_Key)
    );

    always #5 Clk = ~Clk;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] A_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int           n_vec = 0;
    int           n_err = 0;
    logic [7:0]   sbox_m [256];
    logic [127:0] sched [11];
    logic [131:0] expq [$];
    logic [131:0] mon_e;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        logic [7:0] s;
        s = {a[6:0], 1'b0};
        if (a[7]) s = s ^ 8'h1b;
        return s;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, x);
            sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic build_sched(input logic [127:0] k);
        logic [7:0]  rc;
        logic [31:0] w0, w1, w2, w3, r, t;
        rc = 8'h01;
        sched[0] = k;
        for (int i = 1; i <= 10; i++) begin
            {w0, w1, w2, w3} = sched[i-1];
            r = {w3[23:0], w3[31:24]};
            t = {sbox_m[r[31:24]], sbox_m[r[23:16]], sbox_m[r[15:8]], sbox_m[r[7:0]]}
                ^ {rc, 24'h0};
            w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
            sched[i] = {w0, w1, w2, w3};
            rc = xtime(rc);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Called one ns after an edge; returns one ns after the accept edge (T+1).
    task automatic start_key(input logic [127:0] k);
        build_sched(k);
        for (int i = 0; i <= 10; i++) expq.push_back({4'(i), sched[i]});
        Start  = 1'b1;
        Key_In = k;
        step();
        Start  = 1'b0;
        Key_In = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (Busy && n < 20) begin
            step();
            n++;
        end
        chk(tag, 128'(Busy), 128'(0));
        chk({tag, "_drain"}, 128'(expq.size()), 128'(0));
    endtask

    task automatic rd(input logic [3:0] a, input string tag, input logic [127:0] exp);
        Rd_Addr = a;
        #1;
        chk(tag, Rd_Key, exp);
    endtask

    always @(negedge Clk) begin
        if (!Rst) begin
            if (Key_Valid) begin
                if (expq.size() == 0) begin
                    chk("stray_valid", 128'(Key_Valid), 128'(0));
                end else begin
                    mon_e = expq.pop_front();
                    chk("round_idx", 128'(Round_Idx), 128'(mon_e[131:128]));
                    chk("round_key", Round_Key, mon_e[127:0]);
                    chk("done", 128'(Done), 128'(mon_e[131:128] == 4'd10));
                end
            end else begin
                chk("done_idle", 128'(Done), 128'(0));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        #12;
        chk("rst_valid", 128'(Key_Valid), 128'(0));
        chk("rst_busy", 128'(Busy), 128'(0));
        chk("rst_done", 128'(Done), 128'(0));
        chk("rst_ready", 128'(Keys_Ready), 128'(0));
        chk("rst_key", Round_Key, 128'(0));
        chk("rst_idx", 128'(Round_Idx), 128'(0));
        rd(4'd0, "rst_rd0", 128'(0));
        @(negedge Clk);
        Rst = 1'b0;
        step();

        // FIPS-197 key with explicit cycle timing
        start_key(KEY_A);
        chk("t1_busy", 128'(Busy), 128'(1));
        chk("t1_ready", 128'(Keys_Ready), 128'(0));
        repeat (10) step();
        chk("t11_busy", 128'(Busy), 128'(1));
        chk("t11_done", 128'(Done), 128'(1));
        step();
        chk("t12_busy", 128'(Busy), 128'(0));
        chk("t12_ready", 128'(Keys_Ready), 128'(1));
        chk("t12_drain", 128'(expq.size()), 128'(0));
        rd(4'd10, "a_rd10", A_RK10);
        rd(4'd1, "a_rd1", A_RK1);
        rd(4'd12, "a_rd12", 128'(0));
        rd(4'd0, "a_rd0", KEY_A);

        // all-zero key
        start_key(128'(0));
        wait_idle("zero_idle");
        rd(4'd1, "z_rd1", Z_RK1);
        rd(4'd10, "z_rd10", Z_RK10);

        // Start while busy (mid-stream and on the Done cycle) is ignored
        start_key(KEY_A);
        repeat (4) step();
        Start = 1'b1; Key_In = KEY_B;
        step();
        Start = 1'b0;
        repeat (5) step();
        chk("ign_done", 128'(Done), 128'(1));
        Start = 1'b1; Key_In = KEY_B;
        step();
        Start = 1'b0;
        chk("ign_busy_t12", 128'(Busy), 128'(0));
        chk("ign_ready_t12", 128'(Keys_Ready), 128'(1));
        rd(4'd10, "ign_rd10", A_RK10);
        start_key(KEY_B);
        chk("t12_accept", 128'(Busy), 128'(1));
        wait_idle("b_idle");
        for (int i = 0; i <= 10; i++) rd(4'(i), "b_buf", sched[i]);

        // asynchronous reset mid-stream
        start_key(KEY_A);
        repeat (5) step();
        #2;
        Rst = 1'b1;
        #1;
        chk("arst_valid", 128'(Key_Valid), 128'(0));
        chk("arst_busy", 128'(Busy), 128'(0));
        chk("arst_done", 128'(Done), 128'(0));
        chk("arst_ready", 128'(Keys_Ready), 128'(0));
        expq.delete();
        for (int i = 0; i < 16; i++) rd(4'(i), "arst_rd", 128'(0));
        @(negedge Clk);
        Rst = 1'b0;
        step();
        start_key(KEY_B);
        wait_idle("post_rst_idle");
        chk("post_rst_ready", 128'(Keys_Ready), 128'(1));
        for (int i = 0; i <= 10; i++) rd(4'(i), "post_rst_buf", sched[i]);

        // back-to-back: A then B
        start_key(KEY_A);
        wait_idle("bb_a_idle");
        chk("bb_a_ready", 128'(Keys_Ready), 128'(1));
        start_key(KEY_B);
        chk("bb_b_ready_drop", 128'(Keys_Ready), 128'(0));
        wait_idle("bb_b_idle");
        chk("bb_b_ready", 128'(Keys_Ready), 128'(1));
        for (int i = 0; i <= 10; i++) rd(4'(i), "bb_buf", sched[i]);
        rd(4'd15, "bb_rd15", 128'(0));

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
